// File: rtl/api_pkg.sv
// Shared definitions for the host API blocks: command codes, controller states
// and the SDRAM word-to-byte helper.
package api_pkg;

   localparam logic [7:0] CMD_WRITE_MEM = 8'h01;
   localparam logic [7:0] CMD_READ_REG  = 8'h02;
   localparam logic [7:0] CMD_WRITE_REG = 8'h03;
   localparam logic [7:0] CMD_READ_MEM  = 8'h04;

   localparam int RAM_AW = 22;

   typedef enum logic [1:0] {
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_DONE
   } api_state_t;

   // Words leave the reader low byte first.
   function automatic logic [7:0] word_byte(input logic [15:0] word, input logic hi);
      return hi ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/sdram_bus.sv
// Toggle req/ack SDRAM port: a request is outstanding whenever req != ack.
interface sdram_bus;

   logic [21:0] address;
   logic        req;
   logic        ack;
   logic        we;
   logic [1:0]  wm;
   logic [15:0] data_read;

   modport controller (
      output address, req, we, wm,
      input  ack, data_read
   );

   modport memory (
      input  address, req, we, wm,
      output ack, data_read
   );

endinterface

// File: rtl/api_word_fifo.sv
// Synchronous 16-bit word FIFO used as the SDRAM read prefetch buffer.
// Flush empties it in one cycle; pushes when full and pops when empty are dropped.
module api_word_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [15:0]              din,
   input  logic                     pop,
   output logic [15:0]              dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/api_mem_reader.sv
// Host API memory reader: decodes a read command and 3-byte address from the host
// link, then streams SDRAM words out byte by byte through a small prefetch FIFO.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_CMD  | waiting for the command byte
//   ST_ADDR | collecting the three address bytes
//   ST_DATA | prefetching SDRAM words and answering byte requests
//   ST_DONE | unsupported command; idle until the next start
module api_mem_reader
   import api_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [7:0]   rd_data,
   input  logic         rd_valid,
   output logic         rd_ready,
   output logic [7:0]   wr_data,
   input  logic         wr_valid,
   output logic         wr_ready,
   sdram_bus.controller ram
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = CW + 1;

   api_state_t        state;
   api_state_t        state_nxt;
   logic [RAM_AW-1:0] addr;
   logic [1:0]        addr_idx;
   logic              hi_next;
   logic              in_flight;
   logic              discard;
   logic              req_q;

   logic              take_byte;
   logic              send_byte;
   logic              issue;
   logic              complete;
   logic              push;
   logic              pop;

   logic [15:0]       fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [OW-1:0]     occupancy;

   assign ram.address = addr;
   assign ram.req     = req_q;
   assign ram.we      = 1'b0;
   assign ram.wm      = 2'b00;

   assign complete  = in_flight && (req_q == ram.ack);
   // The in-flight word already owns a slot, so it counts against free space.
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, in_flight};
   assign push      = complete && !discard && !start;
   assign pop       = send_byte && hi_next;

   api_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (start),
      .push  (push),
      .din   (ram.data_read),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_CMD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      take_byte = 1'b0;
      send_byte = 1'b0;
      issue     = 1'b0;
      if (start) begin
         state_nxt = ST_CMD;
      end else begin
         case (state)
            ST_CMD: begin
               if (rd_valid && !rd_ready) begin
                  take_byte = 1'b1;
                  state_nxt = (rd_data == CMD_READ_MEM) ? ST_ADDR : ST_DONE;
               end
            end
            ST_ADDR: begin
               if (rd_valid && !rd_ready) begin
                  take_byte = 1'b1;
                  if (addr_idx == 2'd2) begin
                     state_nxt = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               send_byte = wr_valid && !wr_ready && !fifo_empty;
               issue     = !in_flight && (req_q == ram.ack) && !fifo_full
                           && (occupancy < OW'(FIFO_DEPTH));
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr      <= '0;
         addr_idx  <= '0;
         hi_next   <= 1'b0;
         in_flight <= 1'b0;
         discard   <= 1'b0;
         req_q     <= 1'b0;
         rd_ready  <= 1'b0;
         wr_ready  <= 1'b0;
         wr_data   <= '0;
      end else begin
         rd_ready <= take_byte;
         wr_ready <= send_byte;

         if (take_byte && state == ST_ADDR) begin
            addr_idx <= addr_idx + 2'd1;
            case (addr_idx)
               2'd0:    addr[21:15] <= rd_data[6:0];
               2'd1:    addr[14:7]  <= rd_data;
               default: begin
                  addr[6:0] <= rd_data[7:1];
                  hi_next   <= rd_data[0];
               end
            endcase
         end

         if (send_byte) begin
            wr_data <= word_byte(fifo_dout, hi_next);
            hi_next <= !hi_next;
         end

         if (issue) begin
            req_q     <= !req_q;
            in_flight <= 1'b1;
         end

         if (complete) begin
            in_flight <= 1'b0;
            discard   <= 1'b0;
            if (!discard) begin
               addr <= addr + RAM_AW'(1);
            end
         end

         // A read still in flight at start must drain before the next one, and its word is dropped.
         if (start) begin
            addr_idx <= '0;
            hi_next  <= 1'b0;
            discard  <= in_flight && !complete;
         end
      end
   end

endmodule

// File: tb/tb_api_mem_reader.sv
// Directed and randomized bench for api_mem_reader with an SDRAM model and a
// byte-stream reference computed from address arithmetic.
module tb_api_mem_reader;
   import api_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;

   sdram_bus ram_if ();

   api_mem_reader #(
      .FIFO_DEPTH (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .ram      (ram_if)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int rd_pulses   = 0;
   int wr_pulses   = 0;
   int toggles     = 0;
   int lat         = 1;

   logic [15:0] ovr [int];
   logic [15:0] seed16;
   logic [21:0] addr_log [$];

   logic        req_q;
   logic        busy;
   int          cnt;
   logic [21:0] pend_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [21:0] a);
      logic [31:0] h;
      if (ovr.exists(int'(a))) return ovr[int'(a)];
      h = {10'b0, a} * 32'h9E3779B1;
      return h[31:16] ^ seed16;
   endfunction

   // Byte k of a read starting at word a; odd drops the very first low byte.
   function automatic logic [7:0] exp_byte(input logic [21:0] a, input logic odd, input int k);
      int          idx;
      logic [21:0] wa;
      logic [15:0] w;
      idx = k + int'(odd);
      wa  = a + 22'(idx / 2);
      w   = mem_word(wa);
      return (idx % 2 == 1) ? w[15:8] : w[7:0];
   endfunction

   // SDRAM model: one request at a time, answered after lat cycles.
   always @(posedge clk) begin
      if (reset) begin
         ram_if.ack       <= 1'b0;
         ram_if.data_read <= '0;
         req_q            <= 1'b0;
         busy             <= 1'b0;
         cnt              <= 0;
      end else begin
         req_q <= ram_if.req;
         if (ram_if.req !== req_q) begin
            toggles++;
            addr_log.push_back(ram_if.address);
            check("one_outstanding", 32'(busy), 32'd0);
            check("read_we", 32'(ram_if.we), 32'd0);
            busy      <= 1'b1;
            cnt       <= lat;
            pend_addr <= ram_if.address;
         end else if (busy) begin
            if (cnt <= 1) begin
               ram_if.ack       <= req_q;
               ram_if.data_read <= mem_word(pend_addr);
               busy             <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rd_ready) rd_pulses++;
      if (wr_ready) wr_pulses++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rd_data  = b;
      rd_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rd_ready) break;
      end
      rd_valid = 1'b0;
   endtask

   task automatic read_cmd(input logic [21:0] a, input logic odd, input logic junk);
      send(CMD_READ_MEM);
      send({junk, a[21:15]});
      send(a[14:7]);
      send({a[6:0], odd});
   endtask

   task automatic pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic collect(input logic [21:0] a, input logic odd, input int n,
                          input logic b2b, input string tag);
      int got;
      int waited;
      got    = 0;
      waited = 0;
      wr_valid = 1'b1;
      while (got < n && waited < 400) begin
         tick();
         waited++;
         if (wr_ready) begin
            check(tag, 32'(wr_data), 32'(exp_byte(a, odd, got)));
            got++;
            if (!b2b) begin
               wr_valid = 1'b0;
               repeat ($urandom_range(0, 2)) tick();
               wr_valid = 1'b1;
            end
         end
      end
      wr_valid = 1'b0;
      check({tag, "_count"}, 32'(got), 32'(n));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [21:0] a;
      logic [21:0] b;
      logic        odd;
      int          p;
      int          wp;
      int          t0;

      reset    = 1'b1;
      start    = 1'b0;
      rd_valid = 1'b0;
      wr_valid = 1'b0;
      rd_data  = '0;
      seed16   = 16'($urandom);
      ovr[32'h10] = 16'hBEEF;
      ovr[32'h11] = 16'h1234;

      repeat (3) tick();
      check("rst_rd_ready", 32'(rd_ready), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_req", 32'(ram_if.req), 32'd0);
      check("rst_we", 32'(ram_if.we), 32'd0);
      check("rst_wm", 32'(ram_if.wm), 32'd0);
      reset = 1'b0;
      tick();

      // Plain read at 0x10.
      lat = 2;
      rd_pulses = 0;
      send(8'h04); send(8'h00); send(8'h00); send(8'h20);
      collect(22'h10, 1'b0, 4, 1'b1, "s031_byte");
      check("s031_rd_pulses", 32'(rd_pulses), 32'd4);

      // Odd start address.
      pulse_start();
      send(8'h04); send(8'h00); send(8'h00); send(8'h21);
      collect(22'h10, 1'b1, 3, 1'b0, "s032_byte");

      // Address wrap.
      pulse_start();
      addr_log.delete();
      send(8'h04); send(8'h7F); send(8'hFF); send(8'hFE);
      collect(22'h3FFFFF, 1'b0, 4, 1'b0, "s033_byte");
      check("s033_nreq", 32'(addr_log.size() >= 2), 32'd1);
      if (addr_log.size() >= 2) begin
         check("s033_addr0", 32'(addr_log[0]), 32'h3FFFFF);
         check("s033_addr1", 32'(addr_log[1]), 32'h000000);
      end

      // Slow SDRAM, back-to-back byte requests, rd_valid held in DATA.
      lat = 10;
      pulse_start();
      a   = 22'($urandom);
      odd = 1'($urandom);
      read_cmd(a, odd, 1'($urandom));
      tick();
      p = rd_pulses;
      rd_data  = CMD_READ_MEM;
      rd_valid = 1'b1;
      collect(a, odd, 8, 1'b1, "s034_byte");
      rd_valid = 1'b0;
      check("s034_no_rd_in_data", 32'(rd_pulses), 32'(p));

      // Start while a read is in flight, then a new address.
      pulse_start();
      a = 22'($urandom);
      b = a ^ 22'h0155AA;
      read_cmd(a, 1'b0, 1'b0);
      repeat (3) tick();
      check("s035_inflight", 32'(ram_if.req !== ram_if.ack), 32'd1);
      pulse_start();
      odd = 1'($urandom);
      read_cmd(b, odd, 1'b1);
      collect(b, odd, 6, 1'b0, "s035_byte");

      // Unsupported command parks in DONE.
      lat = 1;
      pulse_start();
      t0 = toggles;
      send(CMD_READ_REG);
      tick();
      p  = rd_pulses;
      wp = wr_pulses;
      rd_data  = CMD_READ_MEM;
      rd_valid = 1'b1;
      wr_valid = 1'b1;
      repeat (20) tick();
      rd_valid = 1'b0;
      wr_valid = 1'b0;
      tick();
      check("s036_no_rd", 32'(rd_pulses), 32'(p));
      check("s036_no_wr", 32'(wr_pulses), 32'(wp));
      check("s036_no_req", 32'(toggles), 32'(t0));
      pulse_start();
      a = 22'($urandom);
      read_cmd(a, 1'b0, 1'b0);
      collect(a, 1'b0, 2, 1'b0, "s036_after_start");

      // Reset in the middle of a transfer.
      lat = 3;
      pulse_start();
      a = 22'($urandom);
      read_cmd(a, 1'b1, 1'b0);
      collect(a, 1'b1, 2, 1'b1, "rst_mid_pre");
      reset = 1'b1;
      repeat (2) tick();
      check("rst_mid_rd_ready", 32'(rd_ready), 32'd0);
      check("rst_mid_wr_ready", 32'(wr_ready), 32'd0);
      reset = 1'b0;
      b = 22'($urandom);
      odd = 1'($urandom);
      read_cmd(b, odd, 1'b0);
      collect(b, odd, 5, 1'b0, "rst_mid_post");

      // Randomized transactions.
      for (int i = 0; i < 8; i++) begin
         lat = $urandom_range(1, 6);
         pulse_start();
         a = ($urandom_range(0, 1) == 1) ? 22'h3FFFFF - 22'($urandom_range(0, 2)) : 22'($urandom);
         odd = 1'($urandom);
         read_cmd(a, odd, 1'($urandom));
         collect(a, odd, $urandom_range(1, 9), 1'($urandom), "rand_byte");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/api_mem_reader.md
API_MEM_READER -- requirements
Module: api_mem_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of 16-bit prefetch word entries (power of two, minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  transaction start pulse (chip-select edge).
REQ-005 SHALL have port rd_data  input  8  incoming byte from the host link.
REQ-006 SHALL have port rd_valid  input  1  rd_data is available.
REQ-007 SHALL have port rd_ready  output  1  one-cycle pulse: rd_data has been consumed.
REQ-008 SHALL have port wr_data  output  8  outgoing byte to the host link.
REQ-009 SHALL have port wr_valid  input  1  host link requests the next byte.
REQ-010 SHALL have port wr_ready  output  1  one-cycle pulse: wr_data holds the requested byte.
REQ-011 SHALL have port ram  sdram_bus.controller  -  toggle req/ack SDRAM port (address[21:0], we, wm, data_read[15:0]).

Function
REQ-012 SHALL implement the states CMD, ADDR, DATA and DONE.
REQ-013 In CMD, on rd_valid && !rd_ready, SHALL pulse rd_ready, latch the command byte and go to ADDR, or to DONE if the byte is not CMD_READ_MEM (0x04).
REQ-014 In ADDR, SHALL consume three bytes, one rd_ready pulse each: byte0[6:0] to addr[21:15]; byte1 to addr[14:7]; byte2 to {addr[6:0], odd}; after byte2 SHALL enter DATA.
REQ-015 In DATA, SHALL issue an SDRAM read (we=0, toggle ram.req) only when ram.req==ram.ack, the FIFO has a free slot counting the in-flight word, and at most one request is outstanding.
REQ-016 On ram.ack becoming equal to ram.req, SHALL push ram.data_read into the FIFO in the same cycle and increment the read address, mod 2^22 (0x3FFFFF wraps to 0x000000).
REQ-017 SHALL stream bytes low byte first, then high byte; the FIFO word SHALL be popped after its high byte is sent.
REQ-018 If odd=1, SHALL skip the low byte of the first word only, so the first byte out is data_read[15:8].
REQ-019 On wr_valid && !wr_ready in DATA with the FIFO non-empty, SHALL set wr_data and pulse wr_ready on the next cycle.
REQ-020 With the FIFO empty, SHALL hold wr_ready low until a word is pushed, then respond one cycle later.
REQ-021 SHALL never assert wr_ready outside DATA, and SHALL never assert rd_ready in DATA or DONE.
REQ-022 SHALL serve rd_valid before wr_valid when both are pending in the same cycle.
REQ-023 DONE SHALL ignore all traffic until start.
REQ-024 On start, in any state, SHALL go to CMD and flush the FIFO and the odd flag, and SHALL take precedence over every other event that cycle.
REQ-025 If a request is in flight when start arrives, SHALL let it complete, discard its data, and issue no new request until ram.req==ram.ack.
REQ-026 Reading is unbounded: prefetch SHALL continue while in DATA, limited only by FIFO space.

Reset
REQ-027 On reset SHALL set state=CMD, ram.req=0, ram.we=0, ram.wm=2'b00, rd_ready=0, wr_ready=0, wr_data=0, FIFO empty, odd=0 and the in-flight flag clear.
REQ-028 Reset mid-transfer SHALL abandon the transfer; no FIFO content SHALL survive.

Structure
REQ-029 Command codes (CMD_WRITE_MEM=1, CMD_READ_REG=2, CMD_WRITE_REG=3, CMD_READ_MEM=4) and the state enum SHALL live in shared package api_pkg.
REQ-030 The prefetch buffer SHALL be a sub-module api_word_fifo (synchronous, 16-bit, FIFO_DEPTH entries, push/pop/flush, full/empty/count).

Verification
REQ-031 Scenario: bytes 04,00,00,20 with RAM[0x10]=0xBEEF, RAM[0x11]=0x1234 and 4 wr_valid requests -> wr_data EF,BE,34,12; exactly 4 rd_ready pulses.
REQ-032 Scenario: bytes 04,00,00,21 (addr 0x10, odd) -> first byte BE, then 34.
REQ-033 Scenario: address 0x3FFFFF, 4 bytes requested -> ram.address sequence 0x3FFFFF, 0x000000; data correct.
REQ-034 Scenario: SDRAM ack latency of 10 cycles with back-to-back wr_valid -> at most 1 request outstanding, no wr_ready while the FIFO is empty, no lost or duplicated bytes.
REQ-035 Scenario: start pulsed while a read is in flight, followed by a new 04 command -> stale word discarded; the first byte matches the new address.
REQ-036 Scenario: command byte 0x02 -> state DONE, no ram.req toggle, no wr_ready until start.
